logic_unit_seq: RTL and testbench
=================================

# logic_unit_seq

Parametrised, multi-cycle bitwise logic unit for the ALU datapath. It generalises the fixed 32-bit single-function gate arrays to a WIDTH-bit unit with eight selectable logic operations. The operands are processed SLICE bits per cycle under a start/done handshake, which lets the ALU trade area for latency. It provides a registered result and a zero flag for branch and compare logic.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; N = WIDTH/SLICE slices; SLICE == WIDTH is legal (N = 1).

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin an operation; sampled only when idle.
- op  in  3  operation select, captured with start.
- in1  in  WIDTH  operand A, captured with start.
- in2  in  WIDTH  operand B, captured with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse: out and zero are updated this cycle.
- out  out  WIDTH  result register, held stable between completions.
- zero  out  1  1 when out == 0, updated together with out.

## Operation
- Op encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NOR (~(in1|in2))
  - 100 NAND
  - 101 XNOR
  - 110 ANDN (in1 & ~in2)
  - 111 NOT (~in1; in2 ignored)
- FSM states: IDLE, RUN.
- IDLE:
  - If start = 1, latch in1, in2 and op into internal registers.
  - Clear the slice index to 0 and go to RUN.
  - Set busy = 1.
- RUN, each cycle:
  - Compute slice idx (bits idx*SLICE +: SLICE, LSB slice first) from the latched operands.
  - Write it into an internal accumulator and increment idx.
- RUN, on the edge that writes the last slice (idx == N-1):
  - Copy the full result into out.
  - Set zero = (result == 0).
  - Set done = 1 and busy = 0.
  - Return to IDLE.
- done is cleared on the following edge unless another completion occurs.
- Input rules:
  - start is ignored while busy = 1.
  - Operand and op changes during RUN have no effect (latched copies are used).
- out and zero change only on completion or reset. Intermediate slices never appear on out.
- idx is a ceil(log2(N))-bit counter (minimum 1 bit). The counter must not wrap mid-operation.

## Timing
- Reset values: busy = 0, done = 0, out = 0, zero = 1, state = IDLE, idx = 0.
- Latency:
  - start is sampled at edge E.
  - Slices are written at edges E+1 .. E+N.
  - done is high in the cycle after edge E+N, with out and zero valid from then.
  - N = 1: done is high after edge E+1.
- busy is high in the cycles after edges E .. E+N-1.
- Throughput: the cycle in which done is high is IDLE. start asserted in that cycle is accepted, giving back-to-back operations every N+1 cycles.
- Reset asserted mid-operation:
  - Abort on that edge; all outputs take reset values.
  - No done pulse is produced. Previously held out is lost (becomes 0).
- reset and start in the same cycle: reset wins; start is not accepted.

## Test plan
- Reset check (WIDTH=32, SLICE=8): assert reset 2 cycles -> busy=0, done=0, out=0, zero=1.
- All ops (WIDTH=32, SLICE=8): in1=0xF0F0_1234, in2=0x0FF0_FFFF, op 000..111 -> out equals 0x00F0_1234, 0xFFF0_FFFF, 0xFF00_EDCB, 0x000F_0000, 0xFF0F_EDCB, 0x00FF_1234, 0xF000_0000, 0x0F0F_EDCB. done is exactly 1 cycle, 4 edges after the start edge; zero=0 in every case.
- Zero flag: op=010, in1=in2=0xDEAD_BEEF -> out=0, zero=1. Next op=001 with in1=1, in2=0 -> out=1, zero=0.
- Handshake: change in1/in2/op and pulse start during RUN -> those starts are ignored and the result matches the originally latched operands. start in the done cycle -> accepted, next done 5 cycles later.
- Reset mid-operation: assert reset 2 edges after start -> no done pulse, out=0, zero=1. A new op then completes normally.
- Degenerate parameters: WIDTH=SLICE=16 with op=011, in1=0x00FF, in2=0x0F0F -> out=0xF000, done 1 edge after start. Also WIDTH=64, SLICE=8 -> done after 8 edges.

Source files
------------

// File: rtl/logic_unit_seq_if.sv
// ============================================================================
//  Module      : logic_unit_seq_if
//  Description : Start/done operand bus for the multi-cycle logic unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface logic_unit_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             zero;

    modport master (
        output start, op, in1, in2,
        input  busy, done, out, zero
    );

    modport slave (
        input  start, op, in1, in2,
        output busy, done, out, zero
    );
endinterface

`default_nettype wire

// File: rtl/logic_unit_seq.sv
// ============================================================================
//  Module      : logic_unit_seq
//  Description : WIDTH-bit, eight-function bitwise logic unit, SLICE bits/cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    logic_unit_seq_if.slave   bus
);
    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N - 1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out;
    logic             r_done;
    logic             r_zero;

    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic [SLICE-1:0] w_res;
    logic [WIDTH-1:0] w_acc_next;

    // Operand copies shift right each cycle, so the current slice is always the LSBs.
    assign w_sa = r_a[SLICE-1:0];
    assign w_sb = r_b[SLICE-1:0];

    always_comb begin
        w_res = '0;
        case (r_op)
            3'b000:  w_res = w_sa & w_sb;
            3'b001:  w_res = w_sa | w_sb;
            3'b010:  w_res = w_sa ^ w_sb;
            3'b011:  w_res = ~(w_sa | w_sb);
            3'b100:  w_res = ~(w_sa & w_sb);
            3'b101:  w_res = ~(w_sa ^ w_sb);
            3'b110:  w_res = w_sa & ~w_sb;
            default: w_res = ~w_sa;
        endcase
    end

    // Result slices enter at the top; after N cycles slice 0 has reached the LSBs.
    generate
        if (N == 1) begin : g_single
            assign w_acc_next = w_res;
        end else begin : g_multi
            assign w_acc_next = {w_res, r_acc[WIDTH-1:SLICE]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_idx   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.in1;
                        r_b     <= bus.in2;
                        r_op    <= bus.op;
                        r_idx   <= '0;
                        r_state <= c_S_RUN;
                    end
                end
                c_S_RUN: begin
                    r_a   <= r_a >> SLICE;
                    r_b   <= r_b >> SLICE;
                    r_acc <= w_acc_next;
                    if (r_idx == c_LAST) begin
                        r_out   <= w_acc_next;
                        r_zero  <= (w_acc_next == '0);
                        r_done  <= 1'b1;
                        r_state <= c_S_IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state == c_S_RUN);
    assign bus.done = r_done;
    assign bus.out  = r_out;
    assign bus.zero = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_seq.sv
// ============================================================================
//  Module      : tb_logic_unit_seq
//  Description : Directed self-checking bench for logic_unit_seq (three configs).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_unit_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic_unit_seq_if #(.WIDTH(32)) bus32 ();
    logic_unit_seq_if #(.WIDTH(16)) bus16 ();
    logic_unit_seq_if #(.WIDTH(64)) bus64 ();

    logic_unit_seq #(.WIDTH(32), .SLICE(8))  u_dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
    logic_unit_seq #(.WIDTH(16), .SLICE(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
    logic_unit_seq #(.WIDTH(64), .SLICE(8))  u_dut64 (.clk(clk), .reset(reset), .bus(bus64.slave));

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [63:0] c_A = 64'hF0F0_1234;
    localparam logic [63:0] c_B = 64'h0FF0_FFFF;

    logic [31:0] exp_ops [8] = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'h000F_0000,
                                 32'hFF0F_EDCB, 32'h00FF_1234, 32'hF000_0000, 32'h0F0F_EDCB};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input int sel, input logic st, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        case (sel)
            0: begin bus32.start = st; bus32.op = op; bus32.in1 = a[31:0]; bus32.in2 = b[31:0]; end
            1: begin bus16.start = st; bus16.op = op; bus16.in1 = a[15:0]; bus16.in2 = b[15:0]; end
            default: begin bus64.start = st; bus64.op = op; bus64.in1 = a; bus64.in2 = b; end
        endcase
    endtask

    task automatic sample(input int sel, output logic bz, output logic dn,
                          output logic zr, output logic [63:0] o);
        case (sel)
            0: begin bz = bus32.busy; dn = bus32.done; zr = bus32.zero; o = 64'(bus32.out); end
            1: begin bz = bus16.busy; dn = bus16.done; zr = bus16.zero; o = 64'(bus16.out); end
            default: begin bz = bus64.busy; dn = bus64.done; zr = bus64.zero; o = bus64.out; end
        endcase
    endtask

    // Waits (bounded) for done; cnt counts negedges since the start was driven.
    task automatic wait_done(input int sel, input string tag, input int cnt0,
                             input logic [63:0] exp, input int lat);
        logic bz, dn, zr;
        logic [63:0] o;
        int cnt;
        cnt = cnt0;
        sample(sel, bz, dn, zr, o);
        while (!dn && cnt < 40) begin
            @(negedge clk);
            cnt++;
            sample(sel, bz, dn, zr, o);
        end
        check({tag, " latency"}, 64'(cnt), 64'(lat));
        check({tag, " out"}, o, exp);
        check({tag, " zero"}, 64'(zr), 64'(exp == 64'd0));
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input int sel, input string tag, input logic [2:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat);
        drive(sel, 1'b1, op, a, b);
        @(negedge clk);
        drive(sel, 1'b0, op, a, b);
        wait_done(sel, tag, 1, exp, lat);
    endtask

    task automatic done_clears(input int sel, input string tag);
        logic bz, dn, zr;
        logic [63:0] o;
        @(negedge clk);
        sample(sel, bz, dn, zr, o);
        check({tag, " done pulse width"}, 64'(dn), 64'd0);
    endtask

    initial begin
        logic bz, dn, zr;
        logic [63:0] o;
        int pulses;

        reset = 1'b1;
        drive(0, 1'b0, 3'b000, 64'd0, 64'd0);
        drive(1, 1'b0, 3'b000, 64'd0, 64'd0);
        drive(2, 1'b0, 3'b000, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        sample(0, bz, dn, zr, o);
        check("reset busy", 64'(bz), 64'd0);
        check("reset done", 64'(dn), 64'd0);
        check("reset out", o, 64'd0);
        check("reset zero", 64'(zr), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(0, $sformatf("op%0d", i), 3'(i), c_A, c_B, 64'(exp_ops[i]), 5);
            done_clears(0, $sformatf("op%0d", i));
        end

        run_op(0, "zero_xor", 3'b010, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'd0, 5);
        run_op(0, "or_one", 3'b001, 64'd1, 64'd0, 64'd1, 5);
        done_clears(0, "or_one");

        // Operand/op changes and repeated starts during RUN must be ignored.
        drive(0, 1'b1, 3'b000, c_A, c_B);
        @(negedge clk);
        drive(0, 1'b1, 3'b111, 64'hFFFF_FFFF, 64'd0);
        sample(0, bz, dn, zr, o);
        check("hs busy", 64'(bz), 64'd1);
        check("hs out held", o, 64'd1);
        @(negedge clk);
        drive(0, 1'b1, 3'b101, 64'h1234_5678, 64'h0);
        @(negedge clk);
        drive(0, 1'b0, 3'b000, 64'd0, 64'd0);
        wait_done(0, "hs", 3, 64'h00F0_1234, 5);
        run_op(0, "b2b", 3'b110, c_A, c_B, 64'hF000_0000, 5);
        done_clears(0, "b2b");

        // Reset two edges after the start edge.
        drive(0, 1'b1, 3'b000, c_A, c_B);
        @(negedge clk);
        drive(0, 1'b0, 3'b000, c_A, c_B);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sample(0, bz, dn, zr, o);
        check("midrst busy", 64'(bz), 64'd0);
        check("midrst done", 64'(dn), 64'd0);
        check("midrst out", o, 64'd0);
        check("midrst zero", 64'(zr), 64'd1);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            sample(0, bz, dn, zr, o);
            if (dn) pulses++;
        end
        check("midrst no done", 64'(pulses), 64'd0);
        run_op(0, "after_rst", 3'b111, c_A, c_B, 64'h0F0F_EDCB, 5);
        @(negedge clk);

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        drive(0, 1'b1, 3'b001, c_A, c_B);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, 3'b000, 64'd0, 64'd0);
        sample(0, bz, dn, zr, o);
        check("rst_start busy", 64'(bz), 64'd0);
        check("rst_start out", o, 64'd0);
        @(negedge clk);
        sample(0, bz, dn, zr, o);
        check("rst_start idle", 64'(bz), 64'd0);

        run_op(1, "w16", 3'b011, 64'h00FF, 64'h0F0F, 64'hF000, 2);
        done_clears(1, "w16");
        run_op(2, "w64", 3'b010, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000,
               64'hFEDC_4567_7654_CDEF, 9);
        done_clears(2, "w64");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
